// File: rtl/rect_flip_seq.sv
// Horizontal mirror of a pixel rectangle in byte-wide BRAM, one adapter word per transaction.
// Each row is processed as word pairs swapped end-for-end with their bytes reversed, plus an odd middle word.
module rect_flip_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_BYTES = 2,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            rect_base,
    input  logic [7:0]                       rect_w,
    input  logic [7:0]                       rect_h,
    input  logic [ADDR_WIDTH-1:0]            row_stride,
    output logic                             busy,
    output logic                             done,
    output logic                             st_read,
    output logic                             st_write,
    output logic [ADDR_WIDTH-1:0]            base_addr,
    output logic [WORD_BYTES*DATA_WIDTH-1:0] write_data,
    input  logic [WORD_BYTES*DATA_WIDTH-1:0] read_data,
    input  logic                             ready
);
    localparam int WW = WORD_BYTES * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(WORD_BYTES);

    typedef enum logic [4:0] {
        S_IDLE, S_ROW_INIT,
        S_RD_L, S_WT_RL, S_CAP_L,
        S_RD_R, S_WT_RR, S_CAP_R,
        S_WR_L, S_WT_WL,
        S_WR_R, S_WT_WR,
        S_RD_M, S_WT_RM, S_CAP_M,
        S_WR_M, S_WT_WM,
        S_DONE
    } state_t;

    function automatic logic [WW-1:0] rev(input logic [WW-1:0] x);
        logic [WW-1:0] y;
        y = '0;
        for (int k = 0; k < WORD_BYTES; k++)
            y[k*DATA_WIDTH +: DATA_WIDTH] = x[(WORD_BYTES-1-k)*DATA_WIDTH +: DATA_WIDTH];
        return y;
    endfunction

    state_t                state, nxt, row_end;
    logic [ADDR_WIDTH-1:0] base_q, base_n, stride_q, stride_n;
    logic [7:0]            w_q, w_n, h_q, h_n;
    logic [ADDR_WIDTH-1:0] row_ptr, row_ptr_n, lptr, lptr_n, rptr, rptr_n;
    logic [7:0]            pair_idx, pair_n, row_idx, row_n;
    logic [WW-1:0]         a_q, a_n, wdata_q, wdata_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic                  busy_q, busy_n, done_q, done_n;
    logic [7:0]            half;
    logic [ADDR_WIDTH-1:0] span;

    assign half    = w_q >> 1;
    assign span    = ADDR_WIDTH'(w_q - 8'd1) * STEP;
    // row_idx has not been advanced yet when this is evaluated
    assign row_end = (row_idx == h_q - 8'd1) ? S_DONE : S_ROW_INIT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            base_q   <= '0;
            stride_q <= '0;
            w_q      <= '0;
            h_q      <= '0;
            row_ptr  <= '0;
            lptr     <= '0;
            rptr     <= '0;
            pair_idx <= '0;
            row_idx  <= '0;
            a_q      <= '0;
            wdata_q  <= '0;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= nxt;
            base_q   <= base_n;
            stride_q <= stride_n;
            w_q      <= w_n;
            h_q      <= h_n;
            row_ptr  <= row_ptr_n;
            lptr     <= lptr_n;
            rptr     <= rptr_n;
            pair_idx <= pair_n;
            row_idx  <= row_n;
            a_q      <= a_n;
            wdata_q  <= wdata_n;
            addr_q   <= addr_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        nxt       = state;
        base_n    = base_q;
        stride_n  = stride_q;
        w_n       = w_q;
        h_n       = h_q;
        row_ptr_n = row_ptr;
        lptr_n    = lptr;
        rptr_n    = rptr;
        pair_n    = pair_idx;
        row_n     = row_idx;
        a_n       = a_q;
        wdata_n   = wdata_q;
        addr_n    = addr_q;
        busy_n    = busy_q;
        done_n    = 1'b0;
        unique case (state)
            S_IDLE: if (start) begin
                base_n   = rect_base;
                stride_n = row_stride;
                w_n      = rect_w;
                h_n      = rect_h;
                row_n    = '0;
                busy_n   = 1'b1;
                nxt      = (rect_w == 8'd0 || rect_h == 8'd0) ? S_DONE : S_ROW_INIT;
            end
            S_ROW_INIT: begin
                row_ptr_n = (row_idx == 8'd0) ? base_q : row_ptr + stride_q;
                lptr_n    = row_ptr_n;
                rptr_n    = row_ptr_n + span;
                pair_n    = '0;
                nxt       = (half != 8'd0) ? S_RD_L : S_RD_M;
            end
            S_RD_L:  nxt = S_WT_RL;
            S_WT_RL: if (ready) nxt = S_CAP_L;
            S_CAP_L: begin
                a_n = read_data;
                nxt = S_RD_R;
            end
            S_RD_R:  nxt = S_WT_RR;
            S_WT_RR: if (ready) nxt = S_CAP_R;
            // B is only ever needed reversed, so it lands straight in the write register
            S_CAP_R: begin
                wdata_n = rev(read_data);
                nxt     = S_WR_L;
            end
            S_WR_L:  nxt = S_WT_WL;
            S_WT_WL: if (ready) begin
                wdata_n = rev(a_q);
                nxt     = S_WR_R;
            end
            S_WR_R:  nxt = S_WT_WR;
            S_WT_WR: if (ready) begin
                lptr_n = lptr + STEP;
                rptr_n = rptr - STEP;
                pair_n = pair_idx + 8'd1;
                if (pair_idx + 8'd1 != half) begin
                    nxt = S_RD_L;
                end else if (w_q[0]) begin
                    nxt = S_RD_M;
                end else begin
                    row_n = row_idx + 8'd1;
                    nxt   = row_end;
                end
            end
            S_RD_M:  nxt = S_WT_RM;
            S_WT_RM: if (ready) nxt = S_CAP_M;
            S_CAP_M: begin
                wdata_n = rev(read_data);
                nxt     = S_WR_M;
            end
            S_WR_M:  nxt = S_WT_WM;
            S_WT_WM: if (ready) begin
                row_n = row_idx + 8'd1;
                nxt   = row_end;
            end
            S_DONE: begin
                done_n = 1'b1;
                busy_n = 1'b0;
                nxt    = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase

        // address is loaded on the edge entering an issue state and held through its wait
        case (nxt)
            S_RD_L, S_WR_L, S_RD_M, S_WR_M: addr_n = lptr_n;
            S_RD_R, S_WR_R:                 addr_n = rptr_n;
            default:                        ;
        endcase
    end

    assign st_read    = (state == S_RD_L) || (state == S_RD_R) || (state == S_RD_M);
    assign st_write   = (state == S_WR_L) || (state == S_WR_R) || (state == S_WR_M);
    assign base_addr  = addr_q;
    assign write_data = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_rect_flip_seq.sv
// Randomized bench: behavioural word adapter over a 256-byte array plus a row-reversal reference model.
module tb_rect_flip_seq;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [7:0]  rect_base = '0, rect_w = '0, rect_h = '0, row_stride = '0;
    logic        busy, done, st_read, st_write;
    logic [7:0]  base_addr;
    logic [15:0] write_data;
    logic [15:0] read_data = '0;
    logic        ready = 1'b0;

    rect_flip_seq #(.DATA_WIDTH(8), .WORD_BYTES(2), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rect_base(rect_base), .rect_w(rect_w), .rect_h(rect_h), .row_stride(row_stride),
        .busy(busy), .done(done), .st_read(st_read), .st_write(st_write),
        .base_addr(base_addr), .write_data(write_data),
        .read_data(read_data), .ready(ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] mem [256];
    logic [8:0] txq [$];
    bit         pend = 0, pend_wr = 0, rd_pend = 0, lat_rand = 0;
    int         cnt = 0, strobes = 0, done_cnt = 0;
    logic [7:0]  p_addr = '0;
    logic [15:0] p_wd = '0;

    function automatic logic [15:0] rd_word(input logic [7:0] a);
        return {mem[8'(a + 8'd1)], mem[a]};
    endfunction

    // adapter: ready a fixed or random number of cycles after each strobe, read data valid one cycle after ready
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 0; rd_pend = 0; ready = 1'b0;
        end else begin
            ready     = 1'b0;
            read_data = rd_pend ? rd_word(p_addr) : 16'($urandom);
            rd_pend   = 0;
            if (done) done_cnt++;
            chk("rw_exclusive", 32'(st_read & st_write), 0);
            if (pend) begin
                chk("addr_hold", base_addr, p_addr);
                if (pend_wr) chk("wdata_hold", write_data, p_wd);
                chk("one_outstanding", 32'(st_read | st_write), 0);
                cnt--;
                if (cnt == 0) begin
                    ready = 1'b1;
                    pend  = 0;
                    if (pend_wr) begin
                        mem[p_addr]            = p_wd[7:0];
                        mem[8'(p_addr + 8'd1)] = p_wd[15:8];
                    end else begin
                        rd_pend = 1;
                    end
                end
            end else if (st_read || st_write) begin
                pend    = 1;
                pend_wr = st_write;
                p_addr  = base_addr;
                p_wd    = write_data;
                cnt     = lat_rand ? int'($urandom_range(1, 7)) : 2;
                txq.push_back({st_write, base_addr});
                strobes++;
            end
        end
    end

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    endtask

    task automatic do_job(input logic [7:0] b, input logic [7:0] w, input logic [7:0] h,
                          input logic [7:0] s, input bit inject, output int lat);
        logic [7:0] refm [256];
        logic [7:0] tmp  [256];
        logic [8:0] expq [$];
        logic [7:0] st, l, rr;
        int n, cyc;
        // reference: each row's bytes reversed in place, rows applied top to bottom
        for (int i = 0; i < 256; i++) refm[i] = mem[i];
        for (int r = 0; r < int'(h); r++) begin
            st = 8'(int'(b) + r * int'(s));
            n  = int'(w) * 2;
            for (int j = 0; j < n; j++) tmp[j] = refm[8'(int'(st) + j)];
            for (int j = 0; j < n; j++) refm[8'(int'(st) + j)] = tmp[n-1-j];
            for (int i = 0; i < int'(w) / 2; i++) begin
                l  = 8'(int'(st) + 2 * i);
                rr = 8'(int'(st) + 2 * (int'(w) - 1 - i));
                expq.push_back({1'b0, l});
                expq.push_back({1'b0, rr});
                expq.push_back({1'b1, l});
                expq.push_back({1'b1, rr});
            end
            if (w[0]) begin
                l = 8'(int'(st) + 2 * (int'(w) / 2));
                expq.push_back({1'b0, l});
                expq.push_back({1'b1, l});
            end
        end

        txq.delete(); strobes = 0; done_cnt = 0;
        @(posedge clk); #1;
        rect_base = b; rect_w = w; rect_h = h; row_stride = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        @(negedge clk);
        chk("busy_rise", 32'(busy), 1);
        while (!done && cyc < 4000) begin
            if (inject && cyc == 10) begin
                start = 1'b1; rect_w = 8'd7; rect_base = 8'h80; rect_h = 8'd1;
            end
            if (inject && cyc == 11) start = 1'b0;
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        lat = cyc;
        chk("done_seen", 32'(done), 1);
        chk("busy_at_done", 32'(busy), 0);
        @(negedge clk); #1;
        chk("done_pulse_width", 32'(done), 0);
        chk("done_count", done_cnt, 1);
        chk("txn_count", txq.size(), expq.size());
        for (int i = 0; i < expq.size(); i++)
            chk("txn_order", (i < txq.size()) ? 32'(txq[i]) : 32'h1ff, 32'(expq[i]));
        for (int i = 0; i < 256; i++) chk("mem", mem[i], refm[i]);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_st_read"}, 32'(st_read), 0);
        chk({tag, "_st_write"}, 32'(st_write), 0);
        chk({tag, "_base_addr"}, 32'(base_addr), 0);
        chk({tag, "_write_data"}, 32'(write_data), 0);
    endtask

    initial begin
        int lat;
        logic [7:0] o0, o1, o2, o3;
        #12;
        chk_outputs_zero("reset");
        @(negedge clk); rst_n = 1'b1;

        // basic single row, fixed latency
        fill_mem();
        for (int k = 0; k < 8; k++) mem[8'h10 + k] = 8'(k);
        do_job(8'h10, 8'd4, 8'd1, 8'h00, 0, lat);
        for (int k = 0; k < 8; k++) chk("t1_mirror", mem[8'h10 + k], 32'(7 - k));
        chk("t1_strobes", strobes, 8);

        // odd width, two rows
        fill_mem();
        do_job(8'h40, 8'd3, 8'd2, 8'h20, 0, lat);
        chk("t2_strobes", strobes, 12);

        // empty rectangles
        fill_mem();
        do_job(8'h20, 8'd0, 8'd3, 8'h10, 0, lat);
        chk("w0_latency", lat, 2);
        chk("w0_strobes", strobes, 0);
        do_job(8'h20, 8'd4, 8'd0, 8'h10, 0, lat);
        chk("h0_latency", lat, 2);
        chk("h0_strobes", strobes, 0);

        // address wrap
        fill_mem();
        o0 = mem[8'hFE]; o1 = mem[8'hFF]; o2 = mem[8'h00]; o3 = mem[8'h01];
        do_job(8'hFE, 8'd2, 8'd1, 8'h00, 0, lat);
        chk("wrap_fe", mem[8'hFE], o3);
        chk("wrap_ff", mem[8'hFF], o2);
        chk("wrap_00", mem[8'h00], o1);
        chk("wrap_01", mem[8'h01], o0);

        // random jobs with random ready latency
        lat_rand = 1;
        for (int t = 0; t < 10; t++) begin
            fill_mem();
            do_job(8'($urandom), 8'($urandom_range(1, 12)), 8'($urandom_range(1, 4)),
                   8'($urandom), 0, lat);
        end

        // start during a job must be ignored
        fill_mem();
        do_job(8'h30, 8'd6, 8'd3, 8'h10, 1, lat);

        // asynchronous reset mid-job, then a fresh job
        fill_mem();
        @(posedge clk); #1;
        rect_base = 8'h30; rect_w = 8'd6; rect_h = 8'd3; row_stride = 8'h10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        chk("pre_reset_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fill_mem();
        do_job(8'h50, 8'd5, 8'd3, 8'h18, 0, lat);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
